bus_xfer_arbiter: RTL

BUS_XFER_ARBITER -- requirements
Module: bus_xfer_arbiter

---
 rtl/bus_xfer_arbiter_if.sv | 29 ++
 rtl/bus_xfer_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bus_xfer_arbiter_if.sv
// Handshake bundle between the requester/slave environment and bus_xfer_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface bus_xfer_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   owner;
  logic            bus_req;
  logic            bus_ack;
  logic            ready;
  logic            transfer_envelope;
  logic            done;
  logic            xfer_ok;
  logic            err;
  logic            busy;

  modport master (
    input  req, bus_ack, ready, done,
    output gnt, owner, bus_req, transfer_envelope, xfer_ok, err, busy
  );

  modport slave (
    output req, bus_ack, ready, done,
    input  gnt, owner, bus_req, transfer_envelope, xfer_ok, err, busy
  );
endinterface

// File: rtl/bus_xfer_arbiter.sv
// Round-robin arbiter granting one requester at a time a single transaction
// (request, acknowledge, bounded data phase, release) on a shared slave.
module bus_xfer_arbiter #(
  parameter int NREQ     = 4,
  parameter int DONE_MAX = 5
) (
  input  logic               clk,
  input  logic               rst,
  bus_xfer_arbiter_if.master bus
);
  localparam int              OW         = $clog2(NREQ);
  localparam logic [3:0]      DONE_LAST  = 4'(DONE_MAX);
  localparam logic [OW-1:0]   LAST_RESET = OW'(NREQ - 1);
  localparam logic [NREQ-1:0] GNT_LSB    = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACK  = 3'd2,
    S_XFER = 3'd3,
    S_REL  = 3'd4
  } state_t;

  state_t          state_r;
  logic [NREQ-1:0] gnt_r;
  logic [OW-1:0]   owner_r;
  logic [OW-1:0]   last_owner_r;
  logic [3:0]      cnt_r;
  logic            env_armed_r;
  logic            bus_req_r;
  logic            xfer_ok_r;
  logic            err_r;
  logic            busy_r;
  logic [OW-1:0]   pick_s;

  // First requesting index found when scanning upward from last+1, wrapping.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [OW-1:0]   last);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && r[OW'(idx)]) begin
        pick  = OW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(bus.req, last_owner_r);

  // Transaction sequencer; every output except the envelope is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      gnt_r        <= '0;
      owner_r      <= '0;
      last_owner_r <= LAST_RESET;
      cnt_r        <= 4'd0;
      env_armed_r  <= 1'b0;
      bus_req_r    <= 1'b0;
      xfer_ok_r    <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (|bus.req) begin
            state_r      <= S_REQ;
            gnt_r        <= GNT_LSB << pick_s;
            owner_r      <= pick_s;
            last_owner_r <= pick_s;
            bus_req_r    <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        S_REQ: begin
          state_r   <= S_ACK;
          bus_req_r <= 1'b0;
        end
        S_ACK: begin
          // done is not looked at here; it only counts from the first XFER cycle
          if (bus.bus_ack) begin
            state_r     <= S_XFER;
            cnt_r       <= 4'd1;
            env_armed_r <= bus.ready;
          end else begin
            state_r <= S_REL;
            err_r   <= 1'b1;
          end
        end
        S_XFER: begin
          if (bus.ready) begin
            env_armed_r <= 1'b1;
          end
          if (bus.done) begin
            state_r     <= S_REL;
            xfer_ok_r   <= 1'b1;
            env_armed_r <= 1'b0;
          end else if (cnt_r == DONE_LAST) begin
            state_r     <= S_REL;
            err_r       <= 1'b1;
            env_armed_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_REL: begin
          state_r   <= S_IDLE;
          gnt_r     <= '0;
          owner_r   <= '0;
          cnt_r     <= 4'd0;
          xfer_ok_r <= 1'b0;
          err_r     <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r     <= S_IDLE;
          gnt_r       <= '0;
          owner_r     <= '0;
          cnt_r       <= 4'd0;
          env_armed_r <= 1'b0;
          bus_req_r   <= 1'b0;
          xfer_ok_r   <= 1'b0;
          err_r       <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt               = gnt_r;
  assign bus.owner             = owner_r;
  assign bus.bus_req           = bus_req_r;
  assign bus.xfer_ok           = xfer_ok_r;
  assign bus.err               = err_r;
  assign bus.busy              = busy_r;
  assign bus.transfer_envelope = (state_r == S_XFER) && (env_armed_r || bus.ready) && !bus.done;
endmodule
